turn_controller: RTL and testbench

- Sequences play for the Connect4 board datapath (the column-drop block with out_gameboard).
- Accepts a player's column choice and rejects illegal or full columns.
- Drives the drop block's state/in_column for exactly one cycle, waits for the board to change, then alternates players.
- Declares win (from an external win checker) or draw after 42 moves.

---
 rtl/turn_controller.sv | 169 ++++++++++++++++
 tb/tb_turn_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// Connect4 turn sequencer: validates column requests, issues one-cycle drop
// commands to the board datapath, waits for the board to change, then scores the move.
module turn_controller #(
  parameter int UPDATE_TIMEOUT = 4,
  parameter int NUM_COLS       = 7,
  parameter int NUM_CELLS      = 42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        drop_req,
  input  logic [2:0]  col_in,
  input  logic [41:0] gameboard,
  input  logic        win_in,
  output logic [1:0]  sel_state,
  output logic [2:0]  sel_column,
  output logic [1:0]  current_player,
  output logic [5:0]  move_count,
  output logic        reject,
  output logic        fault,
  output logic        clear_board,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INPUT, S_ISSUE, S_WAIT_UPDATE, S_CHECK, S_GAME_OVER
  } state_e;

  localparam int              CNT_W    = (UPDATE_TIMEOUT > 1) ? $clog2(UPDATE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_TIMEOUT - 1);
  localparam logic [5:0]      MOVE_MAX = 6'(NUM_CELLS);
  localparam logic [1:0]      P1       = 2'b01;
  localparam logic [1:0]      P2       = 2'b10;

  state_e            state_q, state_d;
  logic [1:0]        player_q, player_d;
  logic [5:0]        move_count_q, move_count_d;
  logic [2:0]        col_q, col_d;
  logic [41:0]       snap_q, snap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        winner_q, winner_d;
  logic              draw_q, draw_d;
  logic              reject_q, reject_d;
  logic              fault_q, fault_d;
  logic              clear_q, clear_d;
  logic              drop_prev_q, drop_prev_d;

  logic              drop_edge;
  logic [7:0]        top_row;
  logic              col_blocked;

  assign drop_edge   = drop_req & ~drop_prev_q;
  // Column 7 maps onto a permanently "full" slot, so one lookup covers both reject causes.
  assign top_row     = {1'b1, gameboard[NUM_CELLS-1 -: NUM_COLS]};
  assign col_blocked = top_row[col_in];

  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can infer a latch.
    state_d      = state_q;
    player_d     = player_q;
    move_count_d = move_count_q;
    col_d        = col_q;
    snap_d       = snap_q;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    draw_d       = draw_q;
    reject_d     = 1'b0;
    fault_d      = 1'b0;
    clear_d      = 1'b0;
    drop_prev_d  = drop_req;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          clear_d      = 1'b1;
          player_d     = P1;
          move_count_d = '0;
          winner_d     = 2'b00;
          draw_d       = 1'b0;
          state_d      = S_WAIT_INPUT;
        end
      end
      S_WAIT_INPUT: begin
        if (drop_edge) begin
          if (col_blocked) begin
            reject_d = 1'b1;
          end else begin
            col_d   = col_in;
            snap_d  = gameboard;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_UPDATE;
      end
      S_WAIT_UPDATE: begin
        if (gameboard != snap_q) begin
          move_count_d = move_count_q + 6'd1;
          state_d      = S_CHECK;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          state_d = S_WAIT_INPUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (win_in) begin
          winner_d = player_q;
          state_d  = S_GAME_OVER;
        end else if (move_count_q == MOVE_MAX) begin
          draw_d  = 1'b1;
          state_d = S_GAME_OVER;
        end else begin
          player_d = (player_q == P1) ? P2 : P1;
          state_d  = S_WAIT_INPUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q      <= S_IDLE;
      player_q     <= 2'b00;
      move_count_q <= '0;
      col_q        <= '0;
      snap_q       <= '0;
      cnt_q        <= '0;
      winner_q     <= 2'b00;
      draw_q       <= 1'b0;
      reject_q     <= 1'b0;
      fault_q      <= 1'b0;
      clear_q      <= 1'b0;
      drop_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_q     <= player_d;
      move_count_q <= move_count_d;
      col_q        <= col_d;
      snap_q       <= snap_d;
      cnt_q        <= cnt_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
      reject_q     <= reject_d;
      fault_q      <= fault_d;
      clear_q      <= clear_d;
      drop_prev_q  <= drop_prev_d;
    end
  end

  assign sel_state      = (state_q == S_ISSUE) ? player_q : 2'b00;
  assign sel_column     = col_q;
  assign current_player = player_q;
  assign move_count     = move_count_q;
  assign reject         = reject_q;
  assign fault          = fault_q;
  assign clear_board    = clear_q;
  assign game_over      = (state_q == S_GAME_OVER);
  assign winner         = winner_q;
  assign draw           = draw_q;

endmodule

// File: tb/tb_turn_controller.sv
// Randomized bench for turn_controller: a game-level reference model queues the
// expected events, a monitor compares them as the DUT presents pulses.
module tb_turn_controller;

  logic        clk = 1'b0;
  logic        reset, start, drop_req, win_in;
  logic [2:0]  col_in;
  logic [41:0] gameboard;
  logic [1:0]  sel_state, current_player, winner;
  logic [2:0]  sel_column;
  logic [5:0]  move_count;
  logic        reject, fault, clear_board, game_over, draw;

  turn_controller dut (
    .clk(clk), .reset(reset), .start(start), .drop_req(drop_req), .col_in(col_in),
    .gameboard(gameboard), .win_in(win_in), .sel_state(sel_state),
    .sel_column(sel_column), .current_player(current_player), .move_count(move_count),
    .reject(reject), .fault(fault), .clear_board(clear_board), .game_over(game_over),
    .winner(winner), .draw(draw)
  );

  always #5 clk = ~clk;

  typedef enum {EV_CLEAR, EV_ISSUE, EV_REJECT, EV_FAULT, EV_OVER} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int player;
    int column;
    int moves;
    int winner;
    int draw;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Game-level reference model: column heights, whose turn, move total.
  typedef enum {G_IDLE, G_PLAY, G_OVER} game_e;
  game_e g_state = G_IDLE;
  int    g_player = 0;
  int    g_moves = 0;
  int    g_heights[7];
  bit    board_ignore = 1'b0;

  task automatic push(input ev_kind_e k, input int p, input int c, input int m,
                      input int w, input int d);
    ev_t e;
    e.kind = k; e.player = p; e.column = c; e.moves = m; e.winner = w; e.draw = d;
    exp_q.push_back(e);
  endtask

  function automatic int pick_legal();
    int c;
    do c = $urandom_range(0, 6); while (g_heights[c] == 6);
    return c;
  endfunction

  function automatic int pick_illegal();
    for (int c = 0; c < 7; c++) if (g_heights[c] == 6) return c;
    return 7;
  endfunction

  // Drop-block stand-in: stacks a piece in the commanded column unless told to stall.
  initial begin
    gameboard = '0;
    forever begin
      @(negedge clk);
      if (reset || clear_board) gameboard = '0;
      else if (sel_state != 2'b00 && !board_ignore) begin
        for (int r = 0; r < 6; r++) begin
          if (!gameboard[r*7 + int'(sel_column)]) begin
            gameboard[r*7 + int'(sel_column)] = 1'b1;
            break;
          end
        end
      end
    end
  end

  task automatic pop_cmp(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", int'(k), -1);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", int'(k), int'(e.kind));
    if (k != e.kind) return;
    case (k)
      EV_CLEAR: begin
        check("clear_player", current_player, 1);
        check("clear_moves", move_count, 0);
        check("clear_winner", winner, 0);
        check("clear_draw", draw, 0);
        check("clear_game_over", game_over, 0);
      end
      EV_ISSUE: begin
        check("issue_sel_state", sel_state, e.player);
        check("issue_sel_column", sel_column, e.column);
        check("issue_moves", move_count, e.moves);
      end
      EV_REJECT, EV_FAULT: begin
        check("hold_player", current_player, e.player);
        check("hold_moves", move_count, e.moves);
        check("hold_sel_state", sel_state, 0);
      end
      default: begin
        check("over_winner", winner, e.winner);
        check("over_draw", draw, e.draw);
        check("over_moves", move_count, e.moves);
        check("over_player", current_player, e.player);
      end
    endcase
  endtask

  initial begin
    bit prev_over = 1'b0;
    forever begin
      @(negedge clk);
      if (clear_board)             pop_cmp(EV_CLEAR);
      if (sel_state != 2'b00)      pop_cmp(EV_ISSUE);
      if (reject)                  pop_cmp(EV_REJECT);
      if (fault)                   pop_cmp(EV_FAULT);
      if (game_over && !prev_over) pop_cmp(EV_OVER);
      prev_over = game_over;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    if (g_state != G_PLAY) begin
      push(EV_CLEAR, 1, 0, 0, 0, 0);
      g_state = G_PLAY; g_player = 1; g_moves = 0;
      for (int c = 0; c < 7; c++) g_heights[c] = 0;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_press(input int col, input bit ignore, input bit win, input bit hold);
    @(negedge clk);
    col_in = col[2:0]; board_ignore = ignore; win_in = win; drop_req = 1'b1;
    if (g_state == G_PLAY) begin
      if (col == 7 || g_heights[col] == 6) push(EV_REJECT, g_player, 0, g_moves, 0, 0);
      else begin
        push(EV_ISSUE, g_player, col, g_moves, 0, 0);
        if (ignore) push(EV_FAULT, g_player, 0, g_moves, 0, 0);
        else begin
          g_heights[col]++;
          g_moves++;
          if (win) begin
            push(EV_OVER, g_player, 0, g_moves, g_player, 0);
            g_state = G_OVER;
          end else if (g_moves == 42) begin
            push(EV_OVER, g_player, 0, g_moves, 0, 1);
            g_state = G_OVER;
          end else g_player = 3 - g_player;
        end
      end
    end
    @(negedge clk);
    if (!hold) drop_req = 1'b0;
    repeat (9) @(negedge clk);
    drop_req = 1'b0;
    @(negedge clk);
    win_in = 1'b0; board_ignore = 1'b0;
  endtask

  task automatic play_moves(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      if (noise && $urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0:       do_press(7, 1'b0, 1'b0, 1'b0);
          1:       do_press(pick_legal(), 1'b1, 1'b0, 1'b0);
          default: do_press(pick_illegal(), 1'b0, 1'b0, 1'b0);
        endcase
      end
      do_press(pick_legal(), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; drop_req = 1'b0; win_in = 1'b0; col_in = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_sel_state", sel_state, 0);
    check("rst_player", current_player, 0);
    check("rst_moves", move_count, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);
    check("rst_pulses", {reject, fault, clear_board, draw}, 0);
    reset = 1'b0;

    do_press(2, 1'b0, 1'b0, 1'b0);            // idle: ignored
    do_start();
    do_press(0, 1'b0, 1'b0, 1'b0);            // P1 into column 0
    do_press(7, 1'b0, 1'b0, 1'b0);            // illegal column
    for (int i = 0; i < 6; i++) do_press(3, 1'b0, 1'b0, 1'b0);
    do_press(3, 1'b0, 1'b0, 1'b0);            // column 3 full
    do_press(1, 1'b1, 1'b0, 1'b0);            // board stalls: fault
    do_start();                               // ignored mid-game
    do_press(2, 1'b0, 1'b0, 1'b1);            // held button fires once
    if (g_player == 1) play_moves(1, 1'b0);
    do_press(pick_legal(), 1'b0, 1'b1, 1'b0); // P2 wins
    do_press(4, 1'b0, 1'b0, 1'b0);            // ignored after game over
    do_start();

    play_moves(42, 1'b1);                     // draw
    do_start();
    play_moves(41, 1'b1);
    do_press(pick_legal(), 1'b0, 1'b1, 1'b0); // win on the 42nd move
    do_start();
    play_moves($urandom_range(3, 20), 1'b1);
    do_press(pick_legal(), 1'b0, 1'b1, 1'b0);
    do_start();

    // Reset arriving while the drop command is on the bus.
    @(negedge clk);
    col_in = 3'd4; drop_req = 1'b1;
    push(EV_ISSUE, g_player, 4, g_moves, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      drop_req = 1'b0;
      if (sel_state != 2'b00) found = 1'b1;
    end
    check("issue_seen_before_reset", int'(found), 1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_reset_sel_state", sel_state, 0);
    check("mid_reset_player", current_player, 0);
    check("mid_reset_moves", move_count, 0);
    check("mid_reset_game_over", game_over, 0);
    reset = 1'b0;
    g_state = G_IDLE;
    do_start();
    do_press(5, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("pending_expected", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
